// File: rtl/johnson_phase_monitor.sv
// Tracks a 4-bit Johnson counter sampled half a cycle after it changes.
// Locks after LOCK_COUNT consecutive legal steps, flags breaks, and counts revolutions.
//
// state  | meaning
// -------+------------------------------------------------------------
// SYNC   | hunting for LOCK_COUNT consecutive legal successor steps
// LOCKED | sequence confirmed; phase valid, breaks raise error
module johnson_phase_monitor #(
    parameter int LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic [3:0] johnson_in,
    output logic [7:0] phase,
    output logic       locked,
    output logic       error,
    output logic [3:0] err_count,
    output logic [7:0] cycle_count
);

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] LOCK_TARGET = 3'(LOCK_COUNT);

    state_t     state, state_nxt;
    logic [3:0] cur;
    logic [2:0] match_cnt, match_cnt_nxt;
    logic       error_nxt;
    logic [3:0] err_count_nxt;
    logic [7:0] cycle_count_nxt;
    logic       ok;

    function automatic logic code_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: code_legal = 1'b1;
            default:                            code_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] code_index(input logic [3:0] c);
        case (c)
            4'b0001: code_index = 3'd1;
            4'b0011: code_index = 3'd2;
            4'b0111: code_index = 3'd3;
            4'b1111: code_index = 3'd4;
            4'b1110: code_index = 3'd5;
            4'b1100: code_index = 3'd6;
            4'b1000: code_index = 3'd7;
            default: code_index = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] code_succ(input logic [3:0] c);
        code_succ = {c[2:0], ~c[3]};
    endfunction

    // Compared against cur before it is overwritten by this edge's sample.
    assign ok = code_legal(cur) && code_legal(johnson_in) &&
                (johnson_in == code_succ(cur));

    always_comb begin
        state_nxt       = state;
        match_cnt_nxt   = match_cnt;
        error_nxt       = 1'b0;
        err_count_nxt   = err_count;
        cycle_count_nxt = cycle_count;
        case (state)
            SYNC: begin
                if (ok) begin
                    if (match_cnt + 3'd1 == LOCK_TARGET) begin
                        state_nxt     = LOCKED;
                        match_cnt_nxt = 3'd0;
                    end else begin
                        match_cnt_nxt = match_cnt + 3'd1;
                    end
                end else begin
                    match_cnt_nxt = 3'd0;
                end
            end
            LOCKED: begin
                if (ok) begin
                    if (johnson_in == 4'b0000)
                        cycle_count_nxt = cycle_count + 8'd1;
                end else begin
                    state_nxt     = SYNC;
                    match_cnt_nxt = 3'd0;
                    error_nxt     = 1'b1;
                    if (err_count != 4'hF)
                        err_count_nxt = err_count + 4'd1;
                end
            end
            default: begin
                state_nxt     = SYNC;
                match_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state       <= SYNC;
            cur         <= 4'b0000;
            match_cnt   <= 3'd0;
            error       <= 1'b0;
            err_count   <= 4'd0;
            cycle_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            cur         <= johnson_in;
            match_cnt   <= match_cnt_nxt;
            error       <= error_nxt;
            err_count   <= err_count_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        phase = 8'h00;
        if (state == LOCKED)
            phase = 8'h01 << code_index(cur);
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor with LOCK_COUNT = 2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       async_reset;
    logic [3:0] johnson_in;
    logic [7:0] phase;
    logic       locked;
    logic       error;
    logic [3:0] err_count;
    logic [7:0] cycle_count;

    int total = 0;
    int bad   = 0;

    johnson_phase_monitor #(.LOCK_COUNT(2)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .johnson_in  (johnson_in),
        .phase       (phase),
        .locked      (locked),
        .error       (error),
        .err_count   (err_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] code);
        @(negedge clk);
        johnson_in = code;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] c);
        nxt = {c[2:0], ~c[3]};
    endfunction

    logic [3:0] walk_code  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [7:0] walk_phase [8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h01};

    initial begin
        logic [3:0] c;
        int exp_err;

        async_reset = 1'b1;
        johnson_in  = 4'b0000;
        #1;
        check("rst_phase",  {24'd0, phase}, 32'h00);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_error",  {31'd0, error}, 0);
        check("rst_errcnt", {28'd0, err_count}, 0);
        check("rst_cycles", {24'd0, cycle_count}, 0);
        #11;
        async_reset = 1'b0;

        // Free run from 0000: first edge is a stall, lock after 0001, 0011.
        step(4'b0000);
        check("stall0_locked", {31'd0, locked}, 0);
        step(4'b0001);
        check("sync1_locked", {31'd0, locked}, 0);
        for (int i = 1; i < 8; i++) begin
            step(walk_code[i]);
            check("walk_locked", {31'd0, locked}, 1);
            check("walk_phase",  {24'd0, phase}, {24'd0, walk_phase[i]});
            check("walk_error",  {31'd0, error}, 0);
        end
        check("rev1_cycles", {24'd0, cycle_count}, 1);
        step(4'b0001);
        check("walk_wrap_phase", {24'd0, phase}, 32'h02);

        // Finish that revolution plus six more -> 8.
        for (int i = 1; i < 8; i++) step(walk_code[i]);
        for (int r = 0; r < 6; r++)
            for (int i = 0; i < 8; i++) step(walk_code[i]);
        check("rev8_cycles", {24'd0, cycle_count}, 8);
        for (int r = 0; r < 248; r++)
            for (int i = 0; i < 8; i++) step(walk_code[i]);
        check("rev256_wrap", {24'd0, cycle_count}, 0);
        check("rev256_error", {31'd0, error}, 0);

        // Illegal code 0101 while locked at 0011.
        step(4'b0001);
        step(4'b0011);
        check("pre_brk_phase", {24'd0, phase}, 32'h04);
        step(4'b0101);
        check("brk_error",  {31'd0, error}, 1);
        check("brk_errcnt", {28'd0, err_count}, 1);
        check("brk_locked", {31'd0, locked}, 0);
        check("brk_phase",  {24'd0, phase}, 32'h00);
        step(4'b0111);
        check("brk_err_once", {31'd0, error}, 0);
        check("brk_sync0", {31'd0, locked}, 0);
        step(4'b1111);
        check("brk_sync1", {31'd0, locked}, 0);
        step(4'b1110);
        check("brk_relock", {31'd0, locked}, 1);
        check("brk_relock_phase", {24'd0, phase}, 32'h20);

        // Stall at 0111 for two edges.
        step(4'b1100); step(4'b1000); step(4'b0000);
        check("relock_cycles", {24'd0, cycle_count}, 1);
        step(4'b0001); step(4'b0011); step(4'b0111);
        step(4'b0111);
        check("stall_error",  {31'd0, error}, 1);
        check("stall_errcnt", {28'd0, err_count}, 2);
        step(4'b0111);
        check("stall2_error",  {31'd0, error}, 0);
        check("stall2_errcnt", {28'd0, err_count}, 2);

        // Skip 1100 -> 0000 while locked: error only, no revolution counted.
        step(4'b1111); step(4'b1110); step(4'b1100);
        check("skip_pre_locked", {31'd0, locked}, 1);
        step(4'b0000);
        check("skip_error",  {31'd0, error}, 1);
        check("skip_errcnt", {28'd0, err_count}, 3);
        check("skip_cycles", {24'd0, cycle_count}, 1);

        // Lock on an edge that sees 0000: cycle_count must not move.
        step(4'b1100);
        step(4'b1000);
        step(4'b0000);
        check("lock0_locked", {31'd0, locked}, 1);
        check("lock0_phase",  {24'd0, phase}, 32'h01);
        check("lock0_cycles", {24'd0, cycle_count}, 1);

        // Twenty breaks with relock between each; counter saturates at 15.
        c = 4'b0000;
        exp_err = 3;
        for (int k = 0; k < 20; k++) begin
            c = nxt(c); step(c);
            c = nxt(c); step(c);
            c = nxt(c); step(c);
            check("sat_relock", {31'd0, locked}, 1);
            step(4'b0101);
            exp_err = (exp_err < 15) ? exp_err + 1 : 15;
            check("sat_error",  {31'd0, error}, 1);
            check("sat_errcnt", {28'd0, err_count}, exp_err[31:0]);
        end
        check("sat_final", {28'd0, err_count}, 15);

        // Async reset mid-cycle while locked with five revolutions.
        @(negedge clk);
        async_reset = 1'b1;
        #2;
        async_reset = 1'b0;
        c = 4'b0000;
        step(c);
        for (int k = 0; k < 40; k++) begin
            c = nxt(c);
            step(c);
        end
        check("pre_rst_locked", {31'd0, locked}, 1);
        check("pre_rst_cycles", {24'd0, cycle_count}, 5);
        #2;
        async_reset = 1'b1;
        #1;
        check("arst_locked", {31'd0, locked}, 0);
        check("arst_phase",  {24'd0, phase}, 32'h00);
        check("arst_cycles", {24'd0, cycle_count}, 0);
        check("arst_errcnt", {28'd0, err_count}, 0);
        check("arst_error",  {31'd0, error}, 0);
        @(negedge clk);
        async_reset = 1'b0;
        step(4'b0000);
        check("post_rst_stall", {31'd0, locked}, 0);
        check("post_rst_error", {31'd0, error}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
